// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the coordinate type used by the timing
// controller and the pixel generator.
package vga_pkg;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] vga_coord_t;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL      = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned V_TOTAL      = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_timing_controller_if.sv
// Raster timing bundle from the VGA timing controller to the pixel generator / DAC.
interface vga_timing_controller_if;
    import vga_pkg::*;

    vga_coord_t x;
    vga_coord_t y;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       sync_n;
    logic       frame_start;

    modport master (output x, y, pix_en, hsync, vsync, blank_n, sync_n, frame_start);
    modport slave  (input  x, y, pix_en, hsync, vsync, blank_n, sync_n, frame_start);

endinterface

// File: rtl/vga_axis_timer.sv
// One raster axis: wrapping position counter plus sync-pulse and active-area decodes.
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output vga_coord_t cnt,
    output logic       wrap,
    output logic       sync,
    output logic       active
);

    localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (step) begin
            if (wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + COORD_W'(1);
            end
        end
    end

    // sync is high inside the sync pulse; the top turns it into the active-low strobe
    assign wrap   = (cnt == COORD_W'(TOTAL - 1));
    assign sync   = (cnt >= COORD_W'(SYNC_START)) && (cnt < COORD_W'(SYNC_END));
    assign active = (cnt < COORD_W'(ACTIVE));

endmodule

// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA raster timing: pixel-rate divider, x/y counters and sync/blank strobes.
// Optional VGA_SYNC_ALIGN_EN adds one pixel of register delay on the strobes.
module vga_timing_controller
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic                     clk,
    input  logic                     rst,
    vga_timing_controller_if.master  vga
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             pix_en;
    vga_coord_t       h_cnt, v_cnt;
    logic             h_wrap, h_sync, h_active;
    logic             v_wrap, v_sync, v_active;
    logic             v_step;
    logic             hsync_c, vsync_c, blank_n_c, frame_start_c;

    // pix_en is registered, so it rises CLK_DIV clocks after reset release
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en <= (div_cnt == DIV_W'(CLK_DIV - 1));
            if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    assign v_step = pix_en && h_wrap;

    vga_axis_timer #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk    (clk),
        .rst    (rst),
        .step   (pix_en),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .sync   (h_sync),
        .active (h_active)
    );

    vga_axis_timer #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk    (clk),
        .rst    (rst),
        .step   (v_step),
        .cnt    (v_cnt),
        .wrap   (v_wrap),
        .sync   (v_sync),
        .active (v_active)
    );

    assign hsync_c       = ~h_sync;
    assign vsync_c       = ~v_sync;
    assign blank_n_c     = h_active && v_active;
    assign frame_start_c = (h_cnt == '0) && (v_cnt == '0);

    // Last pixel of the frame must land both counters on the origin together
    a_frame_wrap: assert property (@(posedge clk) disable iff (rst)
        (pix_en && h_wrap && v_wrap) |=> frame_start_c);

`ifdef VGA_SYNC_ALIGN_EN
    logic hsync_q, vsync_q, blank_n_q, frame_start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b1;
            frame_start_q <= 1'b1;
        end else if (pix_en) begin
            hsync_q       <= hsync_c;
            vsync_q       <= vsync_c;
            blank_n_q     <= blank_n_c;
            frame_start_q <= frame_start_c;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank_n     = blank_n_q;
    assign vga.frame_start = frame_start_q;
`else
    assign vga.hsync       = hsync_c;
    assign vga.vsync       = vsync_c;
    assign vga.blank_n     = blank_n_c;
    assign vga.frame_start = frame_start_c;
`endif

    assign vga.x      = h_cnt;
    assign vga.y      = v_cnt;
    assign vga.pix_en = pix_en;
    assign vga.sync_n = 1'b0;

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Generates 640x480@60 Hz VGA raster timing from the board clock and feeds the pixel generator directly downstream. Outputs the current pixel coordinate `x`/`y`, which the pixel generator turns into `r`/`g`/`b`. Also outputs the `hsync`, `vsync`, `blank_n` and `sync_n` strobes that go to the DAC and connector. An internal divider derives the pixel rate, so the downstream stage needs no timing logic of its own.

## Interface
- `CLK_DIV`, 2: board clocks per pixel (50 MHz → 25 MHz); legal range 1..16.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal segments in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical segments in lines.
- `clk  in  1`: board clock. One clock domain only.
- `rst  in  1`: synchronous, active-high reset.
- `x  out  10`: horizontal counter, 0..H_TOTAL-1.
- `y  out  10`: vertical counter, 0..V_TOTAL-1.
- `pix_en  out  1`: one-`clk` strobe; the counters advance on the next edge.
- `hsync  out  1`: active-low horizontal sync.
- `vsync  out  1`: active-low vertical sync.
- `blank_n  out  1`: high while (x,y) is inside the active area.
- `sync_n  out  1`: tied 0 (DAC composite sync unused).
- `frame_start  out  1`: high for exactly one pixel period while x==0 and y==0.

## Operation
- H_TOTAL = sum of the H segments = 800; V_TOTAL = sum of the V segments = 525. All counter arithmetic is 10-bit unsigned.
- Divider `div_cnt` runs 0..CLK_DIV-1 and wraps.
  - `pix_en` = (div_cnt == CLK_DIV-1).
  - With CLK_DIV=1, `pix_en` is constantly 1 after reset.
- On `pix_en`, `x` increments.
  - At H_TOTAL-1, `x` wraps to 0 and `y` increments.
  - At V_TOTAL-1 with `x` at H_TOTAL-1, `y` wraps to 0.
  - Both wrap on the same edge.
- `hsync` = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, i.e. x in 656..751.
- `vsync` = 0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, i.e. y in 490..491.
- `blank_n` = (x < H_ACTIVE) && (y < V_ACTIVE).
- Reset state:
  - div_cnt=0, x=0, y=0, pix_en=0.
  - hsync=1, vsync=1, blank_n=1 (reflects (0,0)).
  - sync_n=0, frame_start=1.
- Reset has priority over `pix_en`. Asserting `rst` mid-line or mid-frame returns to the reset state on the next edge. There is no partial-line recovery.
- `x`, `y` and `div_cnt` are registers.
- Without the macro below, the strobes are combinational decodes of the registered `x`/`y`.

## Timing
- `x`/`y` change only on the `clk` edge where `pix_en` was 1. They hold for CLK_DIV clocks.
- First `pix_en` after reset release: CLK_DIV clocks after the edge that sampled `rst`=0.
- Line period = 800×CLK_DIV clocks. Frame period = 525×800×CLK_DIV = 840 000 clocks at CLK_DIV=2.
- Strobe alignment without the macro: `hsync`, `vsync`, `blank_n` and `frame_start` are valid in the same cycle as the `x`/`y` they decode.

## Configuration
- `VGA_SYNC_ALIGN_EN` defined:
  - `hsync`, `vsync`, `blank_n` and `frame_start` pass through one extra register stage, updated on `pix_en`.
  - They therefore lag `x`/`y` by one pixel period, matching a pixel generator with a registered character ROM.
  - Reset values of those registers are the same as listed under Operation.
- Undefined: the strobes are combinational and aligned with `x`/`y`. No extra flops are present.

## Structure
- Package `vga_pkg` holds:
  - default timing constants, plus the derived H_TOTAL, V_TOTAL and sync start/end;
  - a `vga_coord_t` typedef (logic [9:0]) used by this block and by the pixel generator.
- Sub-module `vga_axis_timer`, instantiated twice (horizontal and vertical):
  - parameters: ACTIVE, FP, SYNC, BP;
  - inputs: `clk`, `rst`, `step`;
  - outputs: `cnt`, `wrap`, `sync`, `active`.
  - Horizontal instance: `step` = `pix_en`. Vertical instance: `step` = `pix_en` && h.`wrap`.

## Test plan
- Reset, CLK_DIV=2:
  - x=0, y=0, hsync=1, vsync=1, blank_n=1, frame_start=1.
  - First `pix_en` 2 clocks after release.
  - x=1 after 3 edges.
- Horizontal sweep:
  - hsync falls exactly when x=656 and rises when x=752.
  - blank_n falls at x=640.
  - 1600 clocks per line.
- Vertical wrap:
  - y goes 524→0 on the same edge that x goes 799→0.
  - frame_start pulses once per 840 000 clocks.
  - vsync is low for exactly 2 lines (y=490, 491).
- Mid-frame reset: assert rst at x=300, y=200 → next edge x=0, y=0, div_cnt=0; timing restarts cleanly.
- CLK_DIV=1:
  - pix_en is constant 1 after reset.
  - line = 800 clocks, frame = 420 000 clocks.
- `VGA_SYNC_ALIGN_EN` defined: hsync falls one pixel after x=656, and blank_n falls one pixel after x=640.
